instruction_prefetch_unit: RTL and testbench

INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

---
 rtl/instruction_prefetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetcher: issues one memory read at a time and queues returned
// words with their addresses in a small FIFO for the control unit.
module instruction_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] I,
  output logic [31:0] I_pc,
  output logic        I_valid,
  input  logic        I_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DROP
  } state_e;

  state_e        state_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   fetch_pc_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  // A redirect flushes the queue and suppresses any push or pop that cycle.
  always_comb begin
    push     = (state_q == ST_REQ) && mem_ack && !redirect;
    pop      = (count_q != '0) && I_ready && !redirect;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      instr_mem[wr_ptr_q] <= mem_data;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // mem_addr only moves when a new request is issued, so it is stable while
  // a request is outstanding, including one that will be dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc & ~32'h3;
      if ((state_q != ST_IDLE) && !mem_ack) begin
        state_q   <= ST_DROP;
        mem_req_q <= 1'b1;
      end else begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        ST_DROP: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign I_valid  = (count_q != '0);
  assign I        = instr_mem[rd_ptr_q];
  assign I_pc     = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Randomised and directed checks of the prefetcher against a transaction-level
// model: an outstanding-request flag, a discard flag and a queue of fetched words.
module tb_instruction_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] I, I_pc;
  logic        I_valid;
  logic        I_ready = 1'b0;

  instruction_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .I(I), .I_pc(I_pc), .I_valid(I_valid), .I_ready(I_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model
  entry_t      m_q[$];
  bit          m_pend   = 0;
  bit          m_doomed = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_fpc    = RPC;
  int          ack_wait = 0;
  int          ack_cfg  = 0;   // fixed ack delay, or -1 for random 0..3

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare at the falling edge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit     ack;
    bit     was_full;
    entry_t e;
    ack = 0;
    if (m_pend) begin
      if (ack_wait == 0) ack = 1;
      else ack_wait--;
    end
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    I_ready     = rdy;
    mem_ack     = ack;
    mem_data    = ack ? (m_addr ^ KEY) : $urandom();

    if (rst) begin
      m_q.delete();
      m_pend = 0; m_doomed = 0; m_addr = '0; m_fpc = RPC;
    end else if (redir) begin
      m_q.delete();
      m_fpc = rpc & ~32'h3;
      if (m_pend && !ack) m_doomed = 1;
      else begin m_pend = 0; m_doomed = 0; end
    end else begin
      was_full = (m_q.size() >= DEPTH);
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_pend) begin
        if (ack) begin
          if (!m_doomed) begin
            e.pc = m_fpc; e.data = m_addr ^ KEY;
            m_q.push_back(e);
            $display("txn fetch pc=%h data=%h", e.pc, e.data);
            m_fpc = m_fpc + 32'd4;
          end
          m_pend = 0; m_doomed = 0;
        end
      end else if (!was_full) begin
        m_pend = 1; m_addr = m_fpc;
        ack_wait = (ack_cfg < 0) ? int'($urandom_range(0, 3)) : ack_cfg;
      end
    end

    @(posedge clock);
    @(negedge clock);
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_pend});
    chk("mem_addr", mem_addr, m_addr);
    chk("I_valid", {31'b0, I_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("I", I, m_q[0].data);
      chk("I_pc", I_pc, m_q[0].pc);
    end
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
  endtask

  initial begin
    // Scenario 1: reset release and sequential fetch
    ack_cfg = 0;
    do_reset();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_I_valid", {31'b0, I_valid}, 32'd0);
    step(0, 0, '0, 1);
    chk("s1_first_addr", mem_addr, 32'h0);
    step(0, 0, '0, 1);
    chk("s1_first_I", I, 32'hA5A5_0000);
    chk("s1_first_I_pc", I_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, '0, 1);
      chk($sformatf("s1_addr%0d", k), mem_addr, 32'(4 * k));
      step(0, 0, '0, 1);
    end

    // Scenario 2: FIFO fills with no consumer, then one pop frees a slot
    do_reset();
    for (int k = 0; k < 12; k++) step(0, 0, '0, 0);
    chk("s2_req_idle", {31'b0, mem_req}, 32'd0);
    chk("s2_head_pc", I_pc, 32'h0);
    chk("s2_head_I", I, 32'hA5A5_0000);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    chk("s2_refill_req", {31'b0, mem_req}, 32'd1);
    chk("s2_refill_addr", mem_addr, 32'd16);

    // Scenario 3: redirect while a request is outstanding
    do_reset();
    ack_cfg = 3;
    step(0, 0, '0, 1);
    step(0, 1, 32'h100, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 1);
      chk("s3_no_valid", {31'b0, I_valid}, 32'd0);
    end
    step(0, 0, '0, 1);
    chk("s3_new_req", {31'b0, mem_req}, 32'd1);
    chk("s3_new_addr", mem_addr, 32'h100);

    // Scenario 4: redirect coinciding with an ack, unaligned target
    do_reset();
    ack_cfg = 0;
    for (int k = 0; k < 5; k++) step(0, 0, '0, 0);
    step(0, 1, 32'h103, 1);
    chk("s4_flushed", {31'b0, I_valid}, 32'd0);
    chk("s4_idle", {31'b0, mem_req}, 32'd0);
    step(0, 0, '0, 1);
    chk("s4_addr", mem_addr, 32'h100);
    step(0, 0, '0, 0);
    chk("s4_I_pc", I_pc, 32'h100);
    chk("s4_I", I, 32'h100 ^ KEY);

    // Scenario 5: reset while a request is outstanding
    ack_cfg = 3;
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    chk("s5_req_drop", {31'b0, mem_req}, 32'd0);
    chk("s5_valid_drop", {31'b0, I_valid}, 32'd0);
    step(0, 0, '0, 0);
    chk("s5_restart", mem_addr, RPC);

    // Address wrap at the top of the 32-bit space
    ack_cfg = 0;
    step(0, 1, 32'hFFFF_FFF6, 0);
    for (int k = 0; k < 10; k++) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Random traffic
    ack_cfg = -1;
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 15) == 0,
           $urandom(),
           $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
